ps2_key_event_queue: RTL and testbench
======================================

Name: ps2_key_event_queue

Overview:
Sits between ps2_interface2 and scancode_to_ascii in the keyboard path. It consumes raw PS/2 set-2 bytes (is_valid/scan_code) and strips the E0 and F0 prefixes. It tracks shift state and queues make events in a small first-word-fall-through FIFO with a valid/ready handshake. This replaces the ad-hoc "ignore F0/00" register in top.

Parameters:
DEPTH_LOG2, 3, log2 of FIFO depth (default 8 entries).
LSHIFT_CODE, 8'h12, scan code of left shift.
RSHIFT_CODE, 8'h59, scan code of right shift.

Ports:
clk  in  1  system clock (CLK domain, same as ps2_interface2).
reset  in  1  synchronous, active-high reset.
code_valid  in  1  single-cycle strobe: code holds a new byte.
code  in  8  raw scan-code byte.
evt_ready  in  1  consumer accepts the head event this cycle.
evt_valid  out  1  FIFO non-empty; head event presented.
evt_code  out  8  scan code of the head event (prefixes stripped).
evt_extended  out  1  head event was E0-prefixed.
evt_shift  out  1  shift state (either shift held) at time of the keypress.
evt_break  out  1  head event is a release; tied 0 unless BREAK_EVENTS_EN.
shift_held  out  1  live shift state (L or R held).
fifo_count  out  DEPTH_LOG2+1  number of queued events.
overflow  out  1  sticky: an event was dropped because the FIFO was full.

Behaviour:
- Decoder FSM advances only on cycles with code_valid=1. States: IDLE, GOT_E0, GOT_F0, GOT_E0F0.
- IDLE:
  - code=E0 -> GOT_E0.
  - code=F0 -> GOT_F0.
  - code=00 or FF (keyboard error/overrun) -> ignored, stay in IDLE.
  - Any other code -> make(code, ext=0), stay in IDLE.
- GOT_E0:
  - F0 -> GOT_E0F0.
  - E0 -> stay in GOT_E0.
  - 00/FF -> IDLE, nothing emitted.
  - Any other code -> make(code, ext=1), go to IDLE.
- GOT_F0: any code except 00/FF -> break(code, ext=0), go to IDLE. 00/FF -> IDLE, nothing emitted.
- GOT_E0F0: any code except 00/FF -> break(code, ext=1), go to IDLE. 00/FF -> IDLE, nothing emitted.
- Shift tracking, non-extended only:
  - make(LSHIFT_CODE) sets lsh; break clears it. Same for RSHIFT_CODE/rsh.
  - shift_held = lsh|rsh, registered; updates the cycle after the strobe.
  - Shift makes and breaks are never enqueued.
- Enqueue:
  - Each non-shift make pushes {code, ext, shift_held as it was before this byte, break=0}.
  - Breaks are not enqueued (see Optional Feature).
- FIFO:
  - First-word-fall-through. A push at cycle N into an empty FIFO gives evt_valid=1 and the outputs valid at N+1.
  - Pop when evt_valid & evt_ready; the next entry or evt_valid=0 appears the following cycle.
  - Head outputs are stable while evt_valid=1 and evt_ready=0.
  - Full and push without pop -> entry dropped, overflow set to 1 and held until reset.
  - Full with push and pop in the same cycle -> both performed, count unchanged, no overflow.
  - Empty with evt_ready=1 -> no effect.
  - Pointers wrap modulo 2^DEPTH_LOG2; fifo_count ranges 0..2^DEPTH_LOG2.
- Reset (synchronous, any time including mid-prefix):
  - FSM returns to IDLE; lsh/rsh cleared; FIFO emptied.
  - Reset values: evt_valid=0, evt_code=0, evt_extended=0, evt_shift=0, evt_break=0, shift_held=0, fifo_count=0, overflow=0.
  - A code_valid strobe in the reset cycle is ignored.

Optional Feature:
BREAK_EVENTS_EN.
- Defined: non-shift break events are also pushed, with evt_break=1 and evt_shift = shift state at release. Makes still carry evt_break=0.
- Undefined: only makes are queued and evt_break is constant 0.
- The FIFO entry width drops by 1 bit when the macro is undefined.

Test Plan:
- Bytes 1C, F0, 1C with evt_ready=1 -> exactly one event: code=1C, ext=0, shift=0, break=0. evt_valid is high 1 cycle after the 1C strobe; fifo_count returns to 0.
- Bytes 12, 1C, F0, 1C, F0, 12 -> shift_held=1 after the first byte. One event: code=1C, shift=1. shift_held=0 after the final 12.
- Bytes E0, 75, E0, F0, 75 -> one event: code=75, ext=1. With BREAK_EVENTS_EN, a second event: code=75, ext=1, break=1.
- evt_ready=0, 9 makes of 1C..24 (DEPTH_LOG2=3) -> fifo_count=8, overflow=1, head code=1C. Then draining 8 pops yields 1C..23 in order, and overflow stays 1.
- FIFO full, evt_ready=1, new make 2B in the same cycle -> count stays 8, overflow stays 0, and 2B is the last entry drained.
- Bytes E0, F0, then reset pulse, then 1C -> FSM is in IDLE after reset, and one event appears: code=1C, ext=0, break=0.

Source files
------------

// File: rtl/ps2_key_event_queue.sv
// ps2_key_event_queue
//   Sits between the PS/2 byte receiver and the scan-code-to-ASCII stage.
//   It strips the E0/F0 prefixes from raw set-2 bytes and tracks the left and
//   right shift keys. Key-press (make) events are queued in a small
//   first-word-fall-through FIFO that the consumer drains with a valid/ready
//   handshake.
//
//   Optional feature macro: BREAK_EVENTS_EN
//     When defined, non-shift key releases are queued as well, with
//     evt_break=1, and each FIFO entry carries one extra bit.
//     When undefined, only makes are queued and evt_break is tied to 0.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   code_valid   one-cycle strobe: code holds a new byte
//   code         raw scan-code byte
//   evt_ready    consumer takes the head event this cycle
//   evt_valid    FIFO non-empty, head event presented
//   evt_code     head event scan code (prefixes stripped)
//   evt_extended head event was E0-prefixed
//   evt_shift    shift state when the head event's byte arrived
//   evt_break    head event is a release (only with BREAK_EVENTS_EN)
//   shift_held   live shift state (left or right held)
//   fifo_count   number of queued events, 0..2^DEPTH_LOG2
//   overflow     sticky: an event was dropped because the FIFO was full
module ps2_key_event_queue #(
  parameter int         DEPTH_LOG2  = 3,
  parameter logic [7:0] LSHIFT_CODE = 8'h12,
  parameter logic [7:0] RSHIFT_CODE = 8'h59
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  code_valid,
  input  logic [7:0]            code,
  input  logic                  evt_ready,
  output logic                  evt_valid,
  output logic [7:0]            evt_code,
  output logic                  evt_extended,
  output logic                  evt_shift,
  output logic                  evt_break,
  output logic                  shift_held,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

`ifdef BREAK_EVENTS_EN
  localparam int ENTRY_W = 11;
`else
  localparam int ENTRY_W = 10;
`endif

  typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} dec_state_t;

  dec_state_t              state;
  logic                    lsh, rsh;
  logic                    bad_byte;
  logic                    make_evt, brk_evt, dec_ext;
  logic                    shift_key;
  logic                    push, pop, full, do_push;
  logic [ENTRY_W-1:0]      push_data;
  logic [ENTRY_W-1:0]      head;
  logic [ENTRY_W-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]     count;

  // 00 and FF are keyboard error/overrun bytes; they abort any pending prefix.
  assign bad_byte = (code == 8'h00) || (code == 8'hFF);

  // Classify the incoming byte against the current prefix state. A strobe
  // arriving during reset is discarded here so it can't touch the FIFO.
  always_comb begin
    make_evt = 1'b0;
    brk_evt  = 1'b0;
    dec_ext  = 1'b0;
    if (code_valid && !reset && !bad_byte) begin
      case (state)
        IDLE: begin
          if (code != 8'hE0 && code != 8'hF0) make_evt = 1'b1;
        end
        GOT_E0: begin
          if (code != 8'hE0 && code != 8'hF0) begin
            make_evt = 1'b1;
            dec_ext  = 1'b1;
          end
        end
        GOT_F0: begin
          brk_evt = 1'b1;
        end
        GOT_E0F0: begin
          brk_evt = 1'b1;
          dec_ext = 1'b1;
        end
        default: begin
          make_evt = 1'b0;
        end
      endcase
    end
  end

  // Only the plain (non-E0) shift codes count as shift keys; E0-prefixed
  // versions of those codes go through the queue like any other key.
  assign shift_key = !dec_ext && (code == LSHIFT_CODE || code == RSHIFT_CODE);

`ifdef BREAK_EVENTS_EN
  assign push      = (make_evt || brk_evt) && !shift_key;
  assign push_data = {brk_evt, shift_held, dec_ext, code};
`else
  assign push      = make_evt && !shift_key;
  assign push_data = {shift_held, dec_ext, code};
`endif

  // Prefix decoder: moves only on strobed bytes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else if (code_valid) begin
      case (state)
        IDLE: begin
          if (code == 8'hE0)      state <= GOT_E0;
          else if (code == 8'hF0) state <= GOT_F0;
          else                    state <= IDLE;
        end
        GOT_E0: begin
          if (code == 8'hF0)      state <= GOT_E0F0;
          else if (code == 8'hE0) state <= GOT_E0;
          else                    state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Shift key latches: a make sets, a break clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      lsh <= 1'b0;
      rsh <= 1'b0;
    end else if ((make_evt || brk_evt) && !dec_ext) begin
      if (code == LSHIFT_CODE) lsh <= make_evt;
      if (code == RSHIFT_CODE) rsh <= make_evt;
    end
  end

  assign shift_held = lsh | rsh;

  assign full    = (count == FULL_COUNT);
  assign pop     = evt_valid && evt_ready;
  // A full FIFO can still accept an entry when the head leaves the same cycle.
  assign do_push = push && (!full || pop);

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !pop)      count <= count + 1'b1;
      else if (!do_push && pop) count <= count - 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: nothing is read until count says it's valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head       = mem[rd_ptr];
  assign evt_valid  = (count != '0);
  assign fifo_count = count;

  // Head fields read as zero while empty so the reset values are clean.
  assign evt_code     = evt_valid ? head[7:0] : 8'h00;
  assign evt_extended = evt_valid && head[8];
  assign evt_shift    = evt_valid && head[9];
`ifdef BREAK_EVENTS_EN
  assign evt_break    = evt_valid && head[10];
`else
  assign evt_break    = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// tb_ps2_key_event_queue
//   Random and directed byte streams are driven into ps2_key_event_queue. A
//   queue-based model of the keyboard event rules predicts every output.
//   Directed sequences also pin a few hand-computed values.
module tb_ps2_key_event_queue;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       code_valid = 1'b0;
  logic [7:0] code = 8'h00;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_extended;
  logic       evt_shift;
  logic       evt_break;
  logic       shift_held;
  logic [3:0] fifo_count;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       sh;
    logic       brk;
  } evt_t;

  evt_t mq[$];
  logic m_e0 = 1'b0;
  logic m_f0 = 1'b0;
  logic m_l  = 1'b0;
  logic m_r  = 1'b0;
  logic m_ovf = 1'b0;
  logic chk_en = 1'b0;

  ps2_key_event_queue #(.DEPTH_LOG2(3), .LSHIFT_CODE(8'h12), .RSHIFT_CODE(8'h59)) dut (
    .clk(clk), .reset(reset), .code_valid(code_valid), .code(code),
    .evt_ready(evt_ready), .evt_valid(evt_valid), .evt_code(evt_code),
    .evt_extended(evt_extended), .evt_shift(evt_shift), .evt_break(evt_break),
    .shift_held(shift_held), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs from a negedge and return at the next negedge.
  task automatic applyStimulus(input logic cv, input logic [7:0] c, input logic rdy, input logic rst);
    code_valid = cv;
    code       = c;
    evt_ready  = rdy;
    reset      = rst;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic sendByte(input logic [7:0] c, input logic rdy);
    applyStimulus(1'b1, c, rdy, 1'b0);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, rdy, 1'b0);
  endtask

  // Reference model: prefix flags, shift bits and an event queue.
  always @(posedge clk) begin
    logic pop_now, is_make, is_brk, ext_now, snap;
    evt_t e;
    if (reset) begin
      mq.delete();
      m_e0 = 1'b0; m_f0 = 1'b0; m_l = 1'b0; m_r = 1'b0; m_ovf = 1'b0;
    end else begin
      pop_now = (mq.size() != 0) && evt_ready;
      is_make = 1'b0; is_brk = 1'b0; ext_now = m_e0;
      snap = m_l | m_r;
      if (code_valid) begin
        if (code == 8'h00 || code == 8'hFF) begin
          m_e0 = 1'b0; m_f0 = 1'b0;
        end else if (m_f0) begin
          is_brk = 1'b1; m_e0 = 1'b0; m_f0 = 1'b0;
        end else if (code == 8'hE0) begin
          m_e0 = 1'b1;
        end else if (code == 8'hF0) begin
          m_f0 = 1'b1;
        end else begin
          is_make = 1'b1; m_e0 = 1'b0;
        end
      end
      if (pop_now) void'(mq.pop_front());
      if (is_make || is_brk) begin
        if (!ext_now && (code == 8'h12 || code == 8'h59)) begin
          if (code == 8'h12) m_l = is_make;
          else               m_r = is_make;
        end else begin
`ifdef BREAK_EVENTS_EN
          if (1'b1) begin
`else
          if (is_make) begin
`endif
            e.code = code; e.ext = ext_now; e.sh = snap; e.brk = is_brk;
            if (mq.size() < 8) mq.push_back(e);
            else m_ovf = 1'b1;
          end
        end
      end
    end
  end

  // Compare the DUT against the model on every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("evt_valid", 32'(evt_valid), 32'(mq.size() != 0));
      checkOutput("fifo_count", 32'(fifo_count), 32'(mq.size()));
      checkOutput("shift_held", 32'(shift_held), 32'(m_l | m_r));
      checkOutput("overflow", 32'(overflow), 32'(m_ovf));
      if (mq.size() != 0) begin
        checkOutput("evt_code", 32'(evt_code), 32'(mq[0].code));
        checkOutput("evt_extended", 32'(evt_extended), 32'(mq[0].ext));
        checkOutput("evt_shift", 32'(evt_shift), 32'(mq[0].sh));
        checkOutput("evt_break", 32'(evt_break), 32'(mq[0].brk));
      end else begin
        checkOutput("evt_break_empty", 32'(evt_break), 32'(0));
      end
    end
  end

  initial begin
    logic [7:0] exp_c;
    logic [7:0] pool [8];
    int sel;
    pool[0] = 8'hE0; pool[1] = 8'hF0; pool[2] = 8'h00; pool[3] = 8'hFF;
    pool[4] = 8'h12; pool[5] = 8'h59; pool[6] = 8'h1C; pool[7] = 8'h75;

    @(negedge clk);
    applyStimulus(1'b1, 8'h1C, 1'b0, 1'b1);
    chk_en = 1'b1;
    checkOutput("reset_valid", 32'(evt_valid), 32'd0);
    checkOutput("reset_code", 32'(evt_code), 32'd0);
    checkOutput("reset_ext", 32'(evt_extended), 32'd0);
    checkOutput("reset_shift", 32'(evt_shift), 32'd0);
    checkOutput("reset_break", 32'(evt_break), 32'd0);
    checkOutput("reset_held", 32'(shift_held), 32'd0);
    checkOutput("reset_count", 32'(fifo_count), 32'd0);
    checkOutput("reset_ovf", 32'(overflow), 32'd0);

    // 1C F0 1C with ready held high.
    sendByte(8'h1C, 1'b1);
    checkOutput("t1_valid", 32'(evt_valid), 32'd1);
    checkOutput("t1_code", 32'(evt_code), 32'h1C);
    sendByte(8'hF0, 1'b1);
    sendByte(8'h1C, 1'b1);
    idle(1, 1'b1);
    checkOutput("t1_count", 32'(fifo_count), 32'd0);

    // Shift held around a key press.
    sendByte(8'h12, 1'b0);
    checkOutput("t2_held", 32'(shift_held), 32'd1);
    sendByte(8'h1C, 1'b0);
    checkOutput("t2_code", 32'(evt_code), 32'h1C);
    checkOutput("t2_shift", 32'(evt_shift), 32'd1);
    sendByte(8'hF0, 1'b0);
    sendByte(8'h1C, 1'b0);
    sendByte(8'hF0, 1'b0);
    sendByte(8'h12, 1'b0);
    checkOutput("t2_released", 32'(shift_held), 32'd0);
    idle(3, 1'b1);

    // Extended make and break.
    sendByte(8'hE0, 1'b0);
    sendByte(8'h75, 1'b0);
    sendByte(8'hE0, 1'b0);
    sendByte(8'hF0, 1'b0);
    sendByte(8'h75, 1'b0);
    checkOutput("t3_code", 32'(evt_code), 32'h75);
    checkOutput("t3_ext", 32'(evt_extended), 32'd1);
`ifdef BREAK_EVENTS_EN
    checkOutput("t3_count", 32'(fifo_count), 32'd2);
`else
    checkOutput("t3_count", 32'(fifo_count), 32'd1);
`endif
    idle(3, 1'b1);

    // Overflow: nine makes into an eight-entry FIFO.
    for (int i = 0; i < 9; i++) sendByte(8'h1C + 8'(i), 1'b0);
    checkOutput("t4_count", 32'(fifo_count), 32'd8);
    checkOutput("t4_ovf", 32'(overflow), 32'd1);
    checkOutput("t4_head", 32'(evt_code), 32'h1C);
    for (int i = 0; i < 8; i++) begin
      exp_c = 8'h1C + 8'(i);
      checkOutput("t4_drain", 32'(evt_code), 32'(exp_c));
      idle(1, 1'b1);
    end
    checkOutput("t4_ovf_sticky", 32'(overflow), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 8; i++) sendByte(8'h1C + 8'(i), 1'b0);
    sendByte(8'h2B, 1'b1);
    checkOutput("t5_count", 32'(fifo_count), 32'd8);
    checkOutput("t5_ovf", 32'(overflow), 32'd0);
    idle(7, 1'b1);
    checkOutput("t5_last", 32'(evt_code), 32'h2B);
    idle(1, 1'b1);

    // Reset in the middle of an E0 F0 prefix.
    sendByte(8'hE0, 1'b0);
    sendByte(8'hF0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    sendByte(8'h1C, 1'b0);
    checkOutput("t6_code", 32'(evt_code), 32'h1C);
    checkOutput("t6_ext", 32'(evt_extended), 32'd0);
    checkOutput("t6_break", 32'(evt_break), 32'd0);
    idle(2, 1'b1);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      sel = $urandom_range(0, 9);
      applyStimulus($urandom_range(0, 1) == 1,
                    (sel < 8) ? pool[sel] : 8'($urandom_range(0, 255)),
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 299) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
